// File: rtl/ms_input_arbiter_if.sv
// ms_input_arbiter_if: config, per-flow source and tagged output bundle; slave = arbiter side, master = driver side
interface ms_input_arbiter_if #(
  parameter int FLUX  = 4,
  parameter int DW    = 8,
  parameter int SIZEW = 7,
  parameter int TAGW  = $clog2(FLUX)
) ();
  logic [TAGW+SIZEW-1:0] cfg_din;
  logic                  cfg_write;
  logic [FLUX-1:0]       cfg_full;
  logic [FLUX*DW-1:0]    src_din;
  logic [FLUX-1:0]       src_write;
  logic [FLUX-1:0]       src_full;
  logic [TAGW+DW-1:0]    out_din;
  logic                  out_write;
  logic [FLUX-1:0]       out_full;
  logic [FLUX-1:0]       flow_done;
  modport master (
    output cfg_din, cfg_write, src_din, src_write, out_full,
    input  cfg_full, src_full, out_din, out_write, flow_done
  );
  modport slave (
    input  cfg_din, cfg_write, src_din, src_write, out_full,
    output cfg_full, src_full, out_din, out_write, flow_done
  );
endinterface

// File: rtl/ms_input_arbiter.sv
// ms_input_arbiter: round-robin merge of FLUX pixel flows onto tagged {tag,pel}; ports clk, rst (sync active-low), bus (slave: cfg/src in, out/done out)
module ms_input_arbiter #(
  parameter int FLUX  = 4,
  parameter int DW    = 8,
  parameter int SIZEW = 7,
  parameter int CNTW  = 14,
  parameter int TAGW  = $clog2(FLUX)
) (
  input logic clk,
  input logic rst,
  ms_input_arbiter_if.slave bus
);
  logic [FLUX-1:0]                  active_q, active_d;
  logic [FLUX-1:0][1:0]             cnt_q, cnt_d;
  logic [FLUX-1:0][1:0][DW-1:0]     buf_q, buf_d;
  logic [FLUX-1:0][CNTW-1:0]        in_left_q, in_left_d;
  logic [FLUX-1:0][CNTW-1:0]        out_left_q, out_left_d;
  logic [TAGW-1:0]                  last_grant_q, last_grant_d;
  logic                             grant_prev_q, grant_prev_d;
  logic [TAGW+DW-1:0]               out_din_q, out_din_d;
  logic                             out_write_q, out_write_d;
  logic [FLUX-1:0]                  flow_done_q, flow_done_d;
  logic [FLUX-1:0]                  src_full, elig, push, pop;
  logic [TAGW-1:0]                  cfg_tag, g, cand;
  logic [SIZEW-1:0]                 cfg_e;
  logic [CNTW-1:0]                  sq;
  logic                             found;
  assign {cfg_tag, cfg_e} = bus.cfg_din;
  assign sq = CNTW'(cfg_e) * CNTW'(cfg_e);
  assign bus.cfg_full  = active_q;
  assign bus.src_full  = src_full;
  assign bus.out_din   = out_din_q;
  assign bus.out_write = out_write_q;
  assign bus.flow_done = flow_done_q;
  always_comb begin
    src_full = '0;
    elig = '0;
    for (int i = 0; i < FLUX; i++) begin
      src_full[i] = !active_q[i] || cnt_q[i] == 2'd2 || in_left_q[i] == '0;
      elig[i] = cnt_q[i] != 2'd0 && !bus.out_full[i] && (TAGW'(i) != last_grant_q || !grant_prev_q);
    end
    found = 1'b0;
    g = '0;
    cand = '0;
    for (int k = 1; k <= FLUX; k++) begin
      cand = TAGW'((int'(last_grant_q) + k) % FLUX);
      if (!found && elig[cand]) begin
        found = 1'b1;
        g = cand;
      end
    end
  end
  always_comb begin
    active_d = active_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    in_left_d = in_left_q;
    out_left_d = out_left_q;
    flow_done_d = '0;
    push = '0;
    pop = '0;
    for (int i = 0; i < FLUX; i++) begin
      push[i] = bus.src_write[i] && !src_full[i];
      pop[i] = found && g == TAGW'(i);
      cnt_d[i] = cnt_q[i] + 2'(push[i]) - 2'(pop[i]);
      if (pop[i]) begin
        buf_d[i][0] = buf_q[i][1];
        out_left_d[i] = out_left_q[i] - CNTW'(1);
        if (out_left_q[i] == CNTW'(1)) begin
          flow_done_d[i] = 1'b1;
          active_d[i] = 1'b0;
        end
      end
      // slot after any same-cycle pop: 0 if buffer ends up with one entry, else 1
      if (push[i]) begin
        buf_d[i][1'(cnt_q[i] - 2'(pop[i]))] = bus.src_din[i*DW +: DW];
        in_left_d[i] = in_left_q[i] - CNTW'(1);
      end
      if (bus.cfg_write && cfg_tag == TAGW'(i) && cfg_e != '0 && !active_q[i]) begin
        active_d[i] = 1'b1;
        in_left_d[i] = sq;
        out_left_d[i] = sq;
      end
    end
    out_write_d = found;
    out_din_d = found ? {g, buf_q[g][0]} : '0;
    grant_prev_d = found;
    last_grant_d = found ? g : last_grant_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
      in_left_q <= '0;
      out_left_q <= '0;
      last_grant_q <= TAGW'(FLUX - 1);
      grant_prev_q <= 1'b0;
      out_din_q <= '0;
      out_write_q <= 1'b0;
      flow_done_q <= '0;
    end else begin
      active_q <= active_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      in_left_q <= in_left_d;
      out_left_q <= out_left_d;
      last_grant_q <= last_grant_d;
      grant_prev_q <= grant_prev_d;
      out_din_q <= out_din_d;
      out_write_q <= out_write_d;
      flow_done_q <= flow_done_d;
    end
  end
endmodule

// File: tb/tb_ms_input_arbiter.sv
// tb_ms_input_arbiter: randomized scenarios checked cycle by cycle against a queue-based flow model
module tb_ms_input_arbiter;
  localparam int FLUX = 4, DW = 8, SIZEW = 7, CNTW = 14, TAGW = $clog2(FLUX);
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  ms_input_arbiter_if #(.FLUX(FLUX), .DW(DW), .SIZEW(SIZEW)) bus ();
  ms_input_arbiter #(.FLUX(FLUX), .DW(DW), .SIZEW(SIZEW), .CNTW(CNTW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] mq [FLUX][$];
  bit mact [FLUX];
  int min_l [FLUX];
  int mout [FLUX];
  int mlast;
  bit mgp;
  bit e_wr;
  logic [TAGW+DW-1:0] e_din;
  logic [FLUX-1:0] e_done;
  int wcnt [FLUX];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [FLUX-1:0] m_src_full();
    logic [FLUX-1:0] sf;
    for (int f = 0; f < FLUX; f++) sf[f] = !mact[f] || mq[f].size() == 2 || min_l[f] == 0;
    return sf;
  endfunction
  function automatic logic [FLUX-1:0] m_act();
    logic [FLUX-1:0] a;
    for (int f = 0; f < FLUX; f++) a[f] = mact[f];
    return a;
  endfunction
  function automatic bit m_busy();
    return m_act() != '0;
  endfunction
  // advance the model by one clock edge using the inputs currently driven
  function automatic void model_update();
    logic [FLUX-1:0] sf;
    logic [DW-1:0] pel;
    int ct, ce, g, f;
    bit cok;
    if (!rst) begin
      for (int i = 0; i < FLUX; i++) begin
        mq[i].delete();
        mact[i] = 0;
        min_l[i] = 0;
        mout[i] = 0;
      end
      mlast = FLUX - 1;
      mgp = 0;
      e_wr = 0;
      e_din = '0;
      e_done = '0;
      return;
    end
    sf = m_src_full();
    ct = int'(bus.cfg_din[SIZEW +: TAGW]);
    ce = int'(bus.cfg_din[SIZEW-1:0]);
    cok = bus.cfg_write && ce != 0 && !mact[ct];
    g = -1;
    for (int k = 1; k <= FLUX; k++) begin
      f = (mlast + k) % FLUX;
      if (g < 0 && mq[f].size() > 0 && !bus.out_full[f] && !(mgp && f == mlast)) g = f;
    end
    e_wr = 0;
    e_din = '0;
    e_done = '0;
    if (g >= 0) begin
      pel = mq[g].pop_front();
      e_wr = 1;
      e_din = {TAGW'(g), pel};
      mout[g]--;
      if (mout[g] == 0) begin
        e_done[g] = 1'b1;
        mact[g] = 0;
      end
      mlast = g;
    end
    mgp = g >= 0;
    for (int i = 0; i < FLUX; i++)
      if (bus.src_write[i] && !sf[i]) begin
        mq[i].push_back(bus.src_din[i*DW +: DW]);
        min_l[i]--;
      end
    if (cok) begin
      mact[ct] = 1;
      min_l[ct] = ce * ce;
      mout[ct] = ce * ce;
    end
  endfunction
  task automatic cycle();
    model_update();
    @(negedge clk);
    chk("out_write", 64'(bus.out_write), 64'(e_wr));
    chk("out_din", 64'(bus.out_din), 64'(e_din));
    chk("flow_done", 64'(bus.flow_done), 64'(e_done));
    chk("src_full", 64'(bus.src_full), 64'(m_src_full()));
    chk("cfg_full", 64'(bus.cfg_full), 64'(m_act()));
    if (bus.out_write === 1'b1) wcnt[int'(bus.out_din[DW +: TAGW])]++;
  endtask
  task automatic cfg(input int t, input int e);
    bus.cfg_din = {TAGW'(t), SIZEW'(e)};
    bus.cfg_write = 1'b1;
    bus.src_din = $urandom;
    cycle();
    bus.cfg_write = 1'b0;
  endtask
  task automatic clear_counts();
    for (int f = 0; f < FLUX; f++) wcnt[f] = 0;
  endtask
  task automatic stream_until_idle(input int budget);
    for (int n = 0; n < budget && m_busy(); n++) begin
      bus.src_din = $urandom;
      cycle();
    end
  endtask
  initial begin
    bus.cfg_din = '0;
    bus.cfg_write = 1'b0;
    bus.src_din = '0;
    bus.src_write = '0;
    bus.out_full = '0;
    rst = 1'b0;
    cycle();
    cycle();
    chk("rst_out_write", 64'(bus.out_write), 64'(0));
    chk("rst_out_din", 64'(bus.out_din), 64'(0));
    chk("rst_flow_done", 64'(bus.flow_done), 64'(0));
    chk("rst_cfg_full", 64'(bus.cfg_full), 64'(0));
    chk("rst_src_full", 64'(bus.src_full), 64'(4'hF));
    rst = 1'b1;
    clear_counts();
    bus.src_write = 4'b0001;
    cfg(0, 15);
    stream_until_idle(1000);
    for (int n = 0; n < 4; n++) begin
      bus.src_din = $urandom;
      cycle();
    end
    chk("s1_words", 64'(wcnt[0]), 64'(225));
    chk("s1_src_full", 64'(bus.src_full[0]), 64'(1));
    bus.src_write = '0;
    cfg(2, 0);
    chk("s4_cfg_e0", 64'(bus.cfg_full[2]), 64'(0));
    clear_counts();
    bus.src_write = '1;
    cfg(0, 15);
    cfg(1, 23);
    cfg(2, 39);
    cfg(3, 71);
    for (int cyc = 0; cyc < 15000 && m_busy(); cyc++) begin
      bus.out_full = {1'b0, cyc >= 200 && cyc < 250, 2'b00};
      bus.cfg_write = cyc == 300;
      bus.cfg_din = {TAGW'(1), SIZEW'(8)};
      bus.src_din = $urandom;
      cycle();
      if (cyc == 249) chk("s3_src_full2", 64'(bus.src_full[2]), 64'(1));
      if (cyc == 301) chk("s4_busy_cfg1", 64'(bus.cfg_full[1]), 64'(1));
    end
    bus.cfg_write = 1'b0;
    bus.out_full = '0;
    chk("s2_words0", 64'(wcnt[0]), 64'(225));
    chk("s2_words1", 64'(wcnt[1]), 64'(529));
    chk("s2_words2", 64'(wcnt[2]), 64'(1521));
    chk("s2_words3", 64'(wcnt[3]), 64'(5041));
    clear_counts();
    bus.src_write = 4'b0001;
    cfg(0, 20);
    for (int n = 0; n < 1000 && wcnt[0] < 100; n++) begin
      bus.src_din = $urandom;
      cycle();
    end
    chk("s5_pre_words", 64'(wcnt[0]), 64'(100));
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("s5_out_write", 64'(bus.out_write), 64'(0));
    chk("s5_out_din", 64'(bus.out_din), 64'(0));
    chk("s5_cfg_full", 64'(bus.cfg_full), 64'(0));
    chk("s5_src_full", 64'(bus.src_full), 64'(4'hF));
    clear_counts();
    cfg(0, 11);
    stream_until_idle(1000);
    for (int n = 0; n < 4; n++) cycle();
    chk("s5_words", 64'(wcnt[0]), 64'(121));
    for (int n = 0; n < 3000; n++) begin
      bus.src_write = FLUX'($urandom);
      bus.src_din = $urandom;
      bus.out_full = FLUX'($urandom & $urandom);
      bus.cfg_write = $urandom_range(0, 7) == 0;
      bus.cfg_din = {TAGW'($urandom_range(0, FLUX - 1)), SIZEW'($urandom_range(0, 9))};
      cycle();
    end
    bus.cfg_write = 1'b0;
    bus.out_full = '0;
    bus.src_write = '1;
    stream_until_idle(2000);
    chk("s6_drained", 64'(bus.cfg_full), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
